dsp48a1_mac_sequencer: RTL and testbench

- Sequences one DSP48A1 slice as an unsigned dot-product (multiply-accumulate) engine.
- A requester issues a job of LEN operand pairs on a valid/ready stream.
- The block drives the slice's operand, OPMODE and clock-enable inputs, and tracks the slice pipeline with a validity token shift register so stalls never corrupt the accumulator.
- It returns the 48-bit sum on a valid/ready result port and sits directly beside the slice instance.

---
 rtl/dsp48a1_mac_sequencer_if.sv | 39 +++
 rtl/dsp48a1_mac_sequencer.sv | 99 +++++++++
 tb/tb_dsp48a1_mac_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp48a1_mac_sequencer_if.sv
// rtl/dsp48a1_mac_sequencer_if.sv - job, operand, result and slice-control signals of the MAC sequencer
interface dsp48a1_mac_sequencer_if #(
  parameter int LEN_W = 10
);
  logic             START;
  logic [LEN_W-1:0] LEN;
  logic             BUSY;
  logic             OP_VALID;
  logic             OP_READY;
  logic [17:0]      OP_A;
  logic [17:0]      OP_B;
  logic             RES_VALID;
  logic             RES_READY;
  logic [47:0]      RES_DATA;
  logic [17:0]      DSP_A;
  logic [17:0]      DSP_B;
  logic [17:0]      DSP_D;
  logic [7:0]       DSP_OPMODE;
  logic             DSP_CEA;
  logic             DSP_CEB;
  logic             DSP_CEM;
  logic             DSP_CEOPMODE;
  logic             DSP_CEP;
  logic [47:0]      DSP_P;

  modport slave (
    input  START, LEN, OP_VALID, OP_A, OP_B, RES_READY, DSP_P,
    output BUSY, OP_READY, RES_VALID, RES_DATA,
    output DSP_A, DSP_B, DSP_D, DSP_OPMODE,
    output DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEP
  );

  modport master (
    output START, LEN, OP_VALID, OP_A, OP_B, RES_READY, DSP_P,
    input  BUSY, OP_READY, RES_VALID, RES_DATA,
    input  DSP_A, DSP_B, DSP_D, DSP_OPMODE,
    input  DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEP
  );
endinterface

// File: rtl/dsp48a1_mac_sequencer.sv
// rtl/dsp48a1_mac_sequencer.sv - drives one DSP48A1 slice as an unsigned dot-product engine
module dsp48a1_mac_sequencer #(
  parameter int         LEN_W     = 10,
  parameter logic [7:0] OPM_FIRST = 8'h01,
  parameter logic [7:0] OPM_ACC   = 8'h09
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  dsp48a1_mac_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             zero_q, zero_d;
  logic             tok1_valid_q, tok1_first_q, tok2_valid_q;
  logic             op_ready, res_valid, handshake;

  assign op_ready  = (state_q == S_LOAD);
  assign handshake = bus.OP_VALID && op_ready;

  // Tokens mirror the slice's M and P stages so P is enabled only for real products.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      len_q        <= '0;
      zero_q       <= 1'b0;
      tok1_valid_q <= 1'b0;
      tok1_first_q <= 1'b0;
      tok2_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      len_q        <= len_d;
      zero_q       <= zero_d;
      tok1_valid_q <= handshake;
      tok1_first_q <= handshake && (remaining_q == len_q);
      tok2_valid_q <= tok1_valid_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    zero_d      = zero_q;
    res_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          if (bus.LEN != '0) begin
            remaining_d = bus.LEN;
            len_d       = bus.LEN;
            state_d     = S_LOAD;
          end else begin
            zero_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (handshake) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The edge leaving DRAIN is the one that lands the last product in P.
        if (tok2_valid_q && !tok1_valid_q) state_d = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (bus.RES_READY) begin
          zero_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.BUSY         = (state_q != S_IDLE);
  assign bus.OP_READY     = op_ready;
  assign bus.RES_VALID    = res_valid;
  assign bus.RES_DATA     = (state_q == S_DONE && !zero_q) ? bus.DSP_P : 48'd0;
  assign bus.DSP_A        = bus.OP_A;
  assign bus.DSP_B        = bus.OP_B;
  assign bus.DSP_D        = 18'd0;
  assign bus.DSP_OPMODE   = tok1_first_q ? OPM_FIRST : OPM_ACC;
  assign bus.DSP_CEA      = 1'b1;
  assign bus.DSP_CEB      = 1'b1;
  assign bus.DSP_CEM      = 1'b1;
  assign bus.DSP_CEOPMODE = 1'b1;
  assign bus.DSP_CEP      = tok2_valid_q;

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// tb/tb_dsp48a1_mac_sequencer.sv - bench with a DSP48A1 slice model and a job-level result model
module tb_dsp48a1_mac_sequencer;
  localparam int LEN_W = 10;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  dsp48a1_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

  dsp48a1_mac_sequencer #(
    .LEN_W(LEN_W), .OPM_FIRST(8'h01), .OPM_ACC(8'h09)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Slice: A1/B1 -> M -> P, OPMODE registered alongside M, only P has a clock enable.
  logic [17:0] s_a1, s_b1;
  logic [35:0] s_m;
  logic [7:0]  s_opm;
  logic [47:0] s_p, s_x, s_z;
  always_comb begin
    s_x = (s_opm[1:0] == 2'b01) ? 48'(s_m) : 48'd0;
    s_z = (s_opm[3:2] == 2'b10) ? s_p : 48'd0;
  end
  always @(posedge CLK) begin
    s_a1  <= bus.DSP_A;
    s_b1  <= bus.DSP_B;
    s_m   <= 36'(s_a1) * 36'(s_b1);
    s_opm <= bus.DSP_OPMODE;
    if (bus.DSP_CEP) s_p <= s_z + s_x;
  end
  assign bus.DSP_P = s_p;

  // Job-level model: pairs left, running sum, edge at which the result becomes due.
  int          cyc      = 0;
  int          ready_at = 0;
  int          m_left   = 0;
  int          m_len    = 0;
  int          cep_cnt  = 0;
  logic        m_idle   = 1'b1;
  logic        m_first  = 1'b0;
  logic        hsd1     = 1'b0;
  logic        hsd2     = 1'b0;
  logic        armed    = 1'b0;
  logic [47:0] m_sum    = 48'd0;

  function automatic logic exp_rv();
    return !m_idle && (m_left == 0) && (cyc >= ready_at);
  endfunction

  always @(posedge CLK) begin
    logic erv, hs;
    erv = exp_rv();
    if (bus.DSP_CEP) cep_cnt++;
    if (!RST_N) begin
      m_idle = 1'b1; m_left = 0; m_sum = 48'd0;
      m_first = 1'b0; hsd1 = 1'b0; hsd2 = 1'b0;
    end else begin
      hs      = !m_idle && (m_left > 0) && bus.OP_VALID;
      m_first = hs && (m_left == m_len);
      hsd2    = hsd1;
      hsd1    = hs;
      if (m_idle) begin
        if (bus.START) begin
          m_idle   = 1'b0;
          m_len    = int'(bus.LEN);
          m_left   = m_len;
          m_sum    = 48'd0;
          ready_at = cyc + 1;
        end
      end else if (hs) begin
        m_sum  = m_sum + 48'(bus.OP_A) * 48'(bus.OP_B);
        m_left = m_left - 1;
        if (m_left == 0) ready_at = cyc + 3;
      end else if (erv && bus.RES_READY) begin
        m_idle = 1'b1;
      end
    end
    cyc++;
  end

  always @(negedge CLK) begin
    if (armed && RST_N) begin
      chk("dsp_ab", 64'({bus.DSP_A, bus.DSP_B}), 64'({bus.OP_A, bus.OP_B}));
      chk("dsp_const", 64'({bus.DSP_D, bus.DSP_CEA, bus.DSP_CEB, bus.DSP_CEM, bus.DSP_CEOPMODE}),
          64'({18'd0, 4'hF}));
      chk("busy", 64'(bus.BUSY), 64'(!m_idle));
      chk("op_ready", 64'(bus.OP_READY), 64'(!m_idle && m_left > 0));
      chk("res_valid", 64'(bus.RES_VALID), 64'(exp_rv()));
      if (exp_rv()) chk("res_data", 64'(bus.RES_DATA), 64'(m_sum));
      else if (m_idle) chk("res_data_idle", 64'(bus.RES_DATA), 64'd0);
      chk("dsp_cep", 64'(bus.DSP_CEP), 64'(hsd2));
      chk("dsp_opmode", 64'(bus.DSP_OPMODE), m_first ? 64'h01 : 64'h09);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_job(input int len);
    bus.LEN   = LEN_W'(len);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    cep_cnt   = 0;
  endtask

  task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input int gap,
                           output int hs_edge);
    bus.OP_VALID = 1'b0;
    repeat (gap) tick();
    bus.OP_A     = a;
    bus.OP_B     = b;
    bus.OP_VALID = 1'b1;
    hs_edge      = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.OP_READY) begin
        tick();
        hs_edge = cyc;
        break;
      end
      tick();
    end
    bus.OP_VALID = 1'b0;
    if (hs_edge < 0) chk("op_handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic get_result(output logic [47:0] res, output int rv_edge);
    rv_edge = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.RES_VALID) begin
        rv_edge = cyc;
        break;
      end
      tick();
    end
    if (rv_edge < 0) chk("res_valid_timeout", 64'd0, 64'd1);
    res = bus.RES_DATA;
    bus.RES_READY = 1'b1;
    tick();
    bus.RES_READY = 1'b0;
  endtask

  logic [17:0] av [4];
  logic [17:0] bv [4];

  task automatic do_job(input int len, input int gap, output logic [47:0] res, output int lat);
    int e, last, rv;
    start_job(len);
    last = cyc;
    for (int i = 0; i < len; i++) begin
      send_pair(av[i], bv[i], gap, e);
      last = e;
    end
    get_result(res, rv);
    lat = rv - last;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] res;
    int lat, e, st;
    bus.START = 1'b0; bus.LEN = '0; bus.OP_VALID = 1'b0;
    bus.OP_A = '0; bus.OP_B = '0; bus.RES_READY = 1'b0;
    RST_N = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_op_ready", 64'(bus.OP_READY), 64'd0);
    chk("rst_res_valid", 64'(bus.RES_VALID), 64'd0);
    chk("rst_cep", 64'(bus.DSP_CEP), 64'd0);
    chk("rst_opmode", 64'(bus.DSP_OPMODE), 64'h09);
    chk("rst_res_data", 64'(bus.RES_DATA), 64'd0);
    RST_N = 1'b1;
    armed = 1'b1;
    tick();

    av = '{18'd2, 18'd4, 18'd6, 18'd0};
    bv = '{18'd3, 18'd5, 18'd7, 18'd0};
    do_job(3, 0, res, lat);
    chk("t1_res", 64'(res), 64'd68);
    chk("t1_latency", 64'(lat), 64'd2);
    chk("t1_cep_count", 64'(cep_cnt), 64'd3);
    chk("t1_busy_after", 64'(bus.BUSY), 64'd0);

    do_job(3, 2, res, lat);
    chk("t2_res", 64'(res), 64'd68);
    chk("t2_latency", 64'(lat), 64'd2);
    chk("t2_cep_count", 64'(cep_cnt), 64'd3);

    start_job(0);
    st = cyc;
    chk("t3_res_valid_next", 64'(bus.RES_VALID), 64'd1);
    get_result(res, e);
    chk("t3_res", 64'(res), 64'd0);
    chk("t3_latency", 64'(e - st), 64'd0);
    chk("t3_cep_count", 64'(cep_cnt), 64'd0);

    av[0] = 18'h3FFFF; bv[0] = 18'h3FFFF;
    do_job(1, 0, res, lat);
    chk("t4_res_max", 64'(res), 64'hF_FFF8_0001);
    av[0] = 18'd1; bv[0] = 18'd1;
    do_job(1, 0, res, lat);
    chk("t4_res_cleared", 64'(res), 64'd1);

    start_job(1);
    send_pair(18'd5, 18'd6, 0, e);
    for (int i = 0; i < 10 && !bus.RES_VALID; i++) tick();
    for (int i = 0; i < 5; i++) begin
      bus.START    = ~i[0];
      bus.LEN      = LEN_W'(3);
      bus.OP_VALID = 1'b1;
      tick();
      chk("t5_hold_data", 64'(bus.RES_DATA), 64'd30);
      chk("t5_hold_valid", 64'(bus.RES_VALID), 64'd1);
      chk("t5_hold_op_ready", 64'(bus.OP_READY), 64'd0);
    end
    bus.START = 1'b0;
    bus.OP_VALID = 1'b0;
    get_result(res, e);
    chk("t5_res", 64'(res), 64'd30);
    chk("t5_no_new_job", 64'(bus.BUSY), 64'd0);

    start_job(4);
    send_pair(18'd9, 18'd9, 0, e);
    send_pair(18'd9, 18'd9, 0, e);
    RST_N = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(bus.BUSY), 64'd0);
    chk("t6_rst_cep", 64'(bus.DSP_CEP), 64'd0);
    tick(); tick();
    RST_N = 1'b1;
    tick();
    av = '{18'd1, 18'd1, 18'd0, 18'd0};
    bv = '{18'd1, 18'd1, 18'd0, 18'd0};
    do_job(2, 0, res, lat);
    chk("t6_res", 64'(res), 64'd2);
    chk("t6_cep_count", 64'(cep_cnt), 64'd2);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
